// File: rtl/axi4_bridge_pkg.sv
// Shared types for the AXI4 -> AXI4-Lite write bridge (AW splitter and write issue stage).
// Holds the write-issue FSM state enum, AXI response codes, the per-beat command struct
// and a response-merge helper. Command fields are sized for the widest instance.
package axi4_bridge_pkg;

    // Command struct fields are sized to the largest supported instance; narrower
    // instances zero-extend on the way in and slice on the way out.
    localparam int CMD_ADDR_MAX_W = 64;
    localparam int CMD_ID_MAX_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2,
        BRESP = 2'd3
    } wr_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [CMD_ADDR_MAX_W-1:0] addr;
        logic [2:0]                prot;
        logic [CMD_ID_MAX_W-1:0]   id;
        logic                      last;
    } wr_cmd_t;

    // Burst response is the numerically worst of its beat responses.
    function automatic logic [1:0] resp_merge(input logic [1:0] acc, input logic [1:0] resp);
        return (resp > acc) ? resp : acc;
    endfunction

endpackage

// File: rtl/axi4lite_wr_issue.sv
// Issues one AXI4-Lite AW/W/B write per command beat and folds B responses into one AXI4 B per burst.
// Latency: cmd accept cycle 0, AW/W cycle 1, B cycle 2 at the earliest; one beat every 3 cycles.
// Backpressure: cmd_ready only in IDLE; W is a combinational pass-through; s_b held until s_b_ready.
//
// Ports:
//   clk, rstn               clock, synchronous active-low reset
//   cmd_*                   per-beat command (addr/prot/id/last) from the bridge's AW FIFO
//   s_w_*                   AXI4 write data in (s_w_last only used by the optional last check)
//   s_b_*                   AXI4 write response out, one per burst
//   m_aw_*, m_w_*, m_b_*    AXI4-Lite master write channels
// Optional: define AXI4LITE_WR_ISSUE_LASTCHK_EN to flag s_w_last disagreeing with cmd_last
// as SLVERR on the burst response (unless the burst already carries DECERR).
module axi4lite_wr_issue
    import axi4_bridge_pkg::*;
#(
    parameter int ID_W   = 5,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                rstn,

    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [2:0]          cmd_prot,
    input  logic [ID_W-1:0]     cmd_id,
    input  logic                cmd_last,

    input  logic                s_w_valid,
    output logic                s_w_ready,
    input  logic [DATA_W-1:0]   s_w_data,
    input  logic [DATA_W/8-1:0] s_w_strb,
    input  logic                s_w_last,

    output logic                s_b_valid,
    input  logic                s_b_ready,
    output logic [ID_W-1:0]     s_b_id,
    output logic [1:0]          s_b_resp,

    output logic                m_aw_valid,
    input  logic                m_aw_ready,
    output logic [ADDR_W-1:0]   m_aw_addr,
    output logic [2:0]          m_aw_prot,

    output logic                m_w_valid,
    input  logic                m_w_ready,
    output logic [DATA_W-1:0]   m_w_data,
    output logic [DATA_W/8-1:0] m_w_strb,

    input  logic                m_b_valid,
    output logic                m_b_ready,
    input  logic [1:0]          m_b_resp
);

    wr_state_e  state_q, state_d;
    wr_cmd_t    cmd_q;
    logic       aw_done_q, w_done_q;
    logic [1:0] acc_resp_q;

    // Handshakes are derived from state and inputs directly rather than from the
    // valid outputs, keeping the comb block free of feedback through its own outputs.
    logic aw_fire, w_fire, aw_done_now, w_done_now;
    assign aw_fire     = (state_q == ISSUE) & ~aw_done_q & m_aw_ready;
    assign w_fire      = (state_q == ISSUE) & ~w_done_q & s_w_valid & m_w_ready;
    assign aw_done_now = aw_done_q | aw_fire;
    assign w_done_now  = w_done_q | w_fire;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            acc_resp_q <= RESP_OKAY;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cmd_valid) begin
                cmd_q <= '{addr: CMD_ADDR_MAX_W'(cmd_addr),
                           prot: cmd_prot,
                           id:   CMD_ID_MAX_W'(cmd_id),
                           last: cmd_last};
            end
            if (state_q == ISSUE) begin
                // Flags clear on the way out so the next beat starts clean.
                if (aw_done_now && w_done_now) begin
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end else begin
                    aw_done_q <= aw_done_now;
                    w_done_q  <= w_done_now;
                end
            end
            if (state_q == RESP && m_b_valid) begin
                acc_resp_q <= resp_merge(acc_resp_q, m_b_resp);
            end
            if (state_q == BRESP && s_b_ready) begin
                acc_resp_q <= RESP_OKAY;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cmd_ready  = 1'b0;
        m_aw_valid = 1'b0;
        m_w_valid  = 1'b0;
        s_w_ready  = 1'b0;
        m_b_ready  = 1'b0;
        s_b_valid  = 1'b0;
        case (state_q)
            IDLE: begin
                // Not ready while reset is held, so nothing looks accepted during reset.
                cmd_ready = rstn;
                if (cmd_valid) state_d = ISSUE;
            end
            ISSUE: begin
                m_aw_valid = ~aw_done_q;
                m_w_valid  = s_w_valid & ~w_done_q;
                s_w_ready  = m_w_ready & ~w_done_q;
                if (aw_done_now && w_done_now) state_d = RESP;
            end
            RESP: begin
                m_b_ready = 1'b1;
                if (m_b_valid) state_d = cmd_q.last ? BRESP : IDLE;
            end
            BRESP: begin
                s_b_valid = 1'b1;
                if (s_b_ready) state_d = IDLE;
            end
        endcase
    end

    assign m_aw_addr = cmd_q.addr[ADDR_W-1:0];
    assign m_aw_prot = cmd_q.prot;
    assign m_w_data  = s_w_data;
    assign m_w_strb  = s_w_strb;
    assign s_b_id    = cmd_q.id[ID_W-1:0];

`ifdef AXI4LITE_WR_ISSUE_LASTCHK_EN
    // Sticky for the whole burst; cleared together with the accumulator.
    logic last_err_q;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last_err_q <= 1'b0;
        end else if (state_q == BRESP && s_b_ready) begin
            last_err_q <= 1'b0;
        end else if (w_fire && (s_w_last != cmd_q.last)) begin
            last_err_q <= 1'b1;
        end
    end
    assign s_b_resp = last_err_q ? resp_merge(acc_resp_q, RESP_SLVERR) : acc_resp_q;
`else
    assign s_b_resp = acc_resp_q;
`endif

    // Upper command-field bits (narrow instances) and s_w_last (default build) are
    // intentionally unused; fold them into one sink.
    logic unused_ok;
    assign unused_ok = ^{cmd_q, s_w_last};

endmodule

// File: tb/tb_axi4lite_wr_issue.sv
`timescale 1ns/1ps
`define CHK(nm, a, e) check(nm, 64'(a), 64'(e))
module tb_axi4lite_wr_issue;
    import axi4_bridge_pkg::*;

    localparam int ID_W = 5, ADDR_W = 32, DATA_W = 64, STRB_W = DATA_W/8;
    localparam int TMO = 200;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic cmd_valid = 1'b0, cmd_ready, cmd_last = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [2:0] cmd_prot = '0;
    logic [ID_W-1:0] cmd_id = '0;
    logic s_w_valid = 1'b0, s_w_ready, s_w_last = 1'b0;
    logic [DATA_W-1:0] s_w_data = '0;
    logic [STRB_W-1:0] s_w_strb = '0;
    logic s_b_valid, s_b_ready = 1'b1;
    logic [ID_W-1:0] s_b_id;
    logic [1:0] s_b_resp;
    logic m_aw_valid, m_aw_ready = 1'b1;
    logic [ADDR_W-1:0] m_aw_addr;
    logic [2:0] m_aw_prot;
    logic m_w_valid, m_w_ready = 1'b1;
    logic [DATA_W-1:0] m_w_data;
    logic [STRB_W-1:0] m_w_strb;
    logic m_b_valid = 1'b0, m_b_ready;
    logic [1:0] m_b_resp = '0;

    always #5 clk = ~clk;

    axi4lite_wr_issue #(.ID_W(ID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_prot(cmd_prot), .cmd_id(cmd_id), .cmd_last(cmd_last),
        .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data),
        .s_w_strb(s_w_strb), .s_w_last(s_w_last),
        .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_id(s_b_id), .s_b_resp(s_b_resp),
        .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot),
        .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
        .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp)
    );

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string nm, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s (cycle %0d)", nm, why, cyc);
    endtask

    // ---------------- scoreboard ----------------
    typedef struct packed { logic [ADDR_W-1:0] addr; logic [2:0] prot; } aw_exp_t;
    typedef struct packed { logic [DATA_W-1:0] data; logic [STRB_W-1:0] strb; } w_exp_t;
    typedef struct packed { logic [ID_W-1:0] id; logic [1:0] resp; } b_exp_t;
    aw_exp_t exp_aw[$];
    w_exp_t  exp_w[$];
    b_exp_t  exp_b[$];

    int cmd_hs = 0, aw_hs = 0, w_hs = 0, mb_hs = 0, sb_hs = 0;
    int cmd_cyc = 0, aw_cyc = 0, w_cyc = 0, mb_cyc = 0;

    aw_exp_t ea;
    w_exp_t  ew;
    b_exp_t  eb, prev_sb;
    logic prev_aw_pend = 1'b0, prev_sb_pend = 1'b0;
    logic [ADDR_W-1:0] prev_aw_addr = '0;

    // Monitor: handshakes complete at the following posedge, so sample on negedge.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_aw_pend = 1'b0;
            prev_sb_pend = 1'b0;
        end else begin
            if (prev_aw_pend) begin
                `CHK("aw_hold_valid", m_aw_valid, 1'b1);
                `CHK("aw_hold_addr", m_aw_addr, prev_aw_addr);
            end
            if (prev_sb_pend) begin
                `CHK("sb_hold_valid", s_b_valid, 1'b1);
                `CHK("sb_hold_id", s_b_id, prev_sb.id);
                `CHK("sb_hold_resp", s_b_resp, prev_sb.resp);
            end
            if (cmd_valid && cmd_ready) begin cmd_hs++; cmd_cyc = cyc; end
            if (m_aw_valid && m_aw_ready) begin
                if (exp_aw.size() == 0) fail_evt("aw_extra", "unexpected AW handshake");
                else begin
                    ea = exp_aw.pop_front();
                    `CHK("aw_addr", m_aw_addr, ea.addr);
                    `CHK("aw_prot", m_aw_prot, ea.prot);
                end
                aw_hs++; aw_cyc = cyc;
            end
            if (m_w_valid && m_w_ready) begin
                if (exp_w.size() == 0) fail_evt("w_extra", "unexpected W handshake");
                else begin
                    ew = exp_w.pop_front();
                    `CHK("w_data", m_w_data, ew.data);
                    `CHK("w_strb", m_w_strb, ew.strb);
                end
                w_hs++; w_cyc = cyc;
            end
            if (m_b_valid && m_b_ready) begin mb_hs++; mb_cyc = cyc; end
            if (s_b_valid && s_b_ready) begin
                if (exp_b.size() == 0) fail_evt("sb_extra", "unexpected s_b response");
                else begin
                    eb = exp_b.pop_front();
                    `CHK("sb_id", s_b_id, eb.id);
                    `CHK("sb_resp", s_b_resp, eb.resp);
                end
                sb_hs++;
            end
            prev_aw_pend = m_aw_valid && !m_aw_ready;
            prev_aw_addr = m_aw_addr;
            prev_sb_pend = s_b_valid && !s_b_ready;
            prev_sb      = '{id: s_b_id, resp: s_b_resp};
        end
    end

    // ---------------- per-beat stimulus ----------------
    logic [ADDR_W-1:0] b_addr[4];
    logic [DATA_W-1:0] b_data[4];
    logic [STRB_W-1:0] b_strb[4];
    logic [1:0]        b_resp[4];
    logic              b_wlast[4];
    int b_awd[4], b_wd[4], b_bd[4];
    int beat_cyc[4];

    task automatic sb_sink(input int dly);
        int t = 0;
        if (dly > 0) begin
            s_b_ready = 1'b0;
            @(negedge clk);
            while (!s_b_valid && t < TMO) begin @(negedge clk); t++; end
            if (t >= TMO) fail_evt("sb_wait", "timeout waiting for s_b_valid");
            repeat (dly) begin
                @(posedge clk); @(negedge clk);
                `CHK("sb_bp_cmd_ready", cmd_ready, 1'b0);
            end
            @(posedge clk); #1 s_b_ready = 1'b1;
        end
        t = 0;
        @(negedge clk);
        while (!(s_b_valid && s_b_ready) && t < TMO) begin @(negedge clk); t++; end
        if (t >= TMO) fail_evt("sb_hs", "timeout waiting for s_b handshake");
        @(posedge clk); #1;
    endtask

    task automatic beat(input int k, input bit last, input logic [ID_W-1:0] id,
                        input logic [2:0] prot, input int sb_dly, input bit abort);
        int base_aw, base_w;
        base_aw = aw_hs;
        base_w  = w_hs;
        exp_aw.push_back('{addr: b_addr[k], prot: prot});
        exp_w.push_back('{data: b_data[k], strb: b_strb[k]});
        fork
            begin
                int t = 0;
                cmd_valid = 1'b1; cmd_addr = b_addr[k]; cmd_prot = prot; cmd_id = id; cmd_last = last;
                @(negedge clk);
                while (!cmd_ready && t < TMO) begin @(negedge clk); t++; end
                if (t >= TMO) fail_evt("cmd_accept", "timeout waiting for cmd_ready");
                @(posedge clk); #1;
                cmd_valid = 1'b0; cmd_addr = $urandom; cmd_last = ~last;
            end
            begin
                int t = 0;
                s_w_valid = 1'b1; s_w_data = b_data[k]; s_w_strb = b_strb[k]; s_w_last = b_wlast[k];
                @(negedge clk);
                while (!s_w_ready && t < TMO) begin @(negedge clk); t++; end
                if (t >= TMO) fail_evt("w_accept", "timeout waiting for s_w_ready");
                @(posedge clk); #1;
                s_w_valid = 1'b0; s_w_data = {$urandom, $urandom};
            end
            begin
                if (b_awd[k] > 0) begin
                    m_aw_ready = 1'b0;
                    repeat (b_awd[k]) @(posedge clk);
                    #1 m_aw_ready = 1'b1;
                end
            end
            begin
                if (b_wd[k] > 0) begin
                    m_w_ready = 1'b0;
                    repeat (b_wd[k]) @(posedge clk);
                    #1 m_w_ready = 1'b1;
                end
            end
            begin
                int t = 0;
                while (!(aw_hs > base_aw && w_hs > base_w) && t < TMO) begin @(posedge clk); #1; t++; end
                if (t >= TMO) fail_evt("aw_w_done", "timeout waiting for AW and W handshakes");
                else if (abort) begin
                    // DUT is now waiting for B: pull reset instead of answering.
                    rstn = 1'b0;
                    @(posedge clk); @(negedge clk);
                    `CHK("rst_mid_cmd_ready", cmd_ready, 1'b0);
                    `CHK("rst_mid_aw_valid", m_aw_valid, 1'b0);
                    `CHK("rst_mid_w_valid", m_w_valid, 1'b0);
                    `CHK("rst_mid_s_w_ready", s_w_ready, 1'b0);
                    `CHK("rst_mid_b_ready", m_b_ready, 1'b0);
                    `CHK("rst_mid_sb_valid", s_b_valid, 1'b0);
                    @(posedge clk); #1 rstn = 1'b1;
                end else begin
                    repeat (b_bd[k]) begin @(posedge clk); #1; end
                    m_b_valid = 1'b1; m_b_resp = b_resp[k];
                    t = 0;
                    @(negedge clk);
                    while (!m_b_ready && t < TMO) begin @(negedge clk); t++; end
                    if (t >= TMO) fail_evt("b_accept", "timeout waiting for m_b_ready");
                    @(posedge clk); #1;
                    m_b_valid = 1'b0; m_b_resp = 2'($urandom);
                end
            end
            begin
                if (last && !abort) sb_sink(sb_dly);
            end
        join
    endtask

    // Reference: burst response is the worst beat response; with the last check
    // enabled any beat whose s_w_last disagrees with its position raises it to SLVERR.
    task automatic run_burst(input int n, input logic [ID_W-1:0] id, input logic [2:0] prot, input int sb_dly);
        logic [1:0] model;
        int sb_before;
        model = RESP_OKAY;
        for (int k = 0; k < n; k++) if (b_resp[k] > model) model = b_resp[k];
`ifdef AXI4LITE_WR_ISSUE_LASTCHK_EN
        for (int k = 0; k < n; k++)
            if (b_wlast[k] != (k == n-1) && model < RESP_SLVERR) model = RESP_SLVERR;
`endif
        sb_before = sb_hs;
        exp_b.push_back('{id: id, resp: model});
        for (int k = 0; k < n; k++) begin
            beat(k, k == n-1, id, prot, sb_dly, 1'b0);
            beat_cyc[k] = cmd_cyc;
        end
        `CHK("sb_count_per_burst", sb_hs, sb_before + 1);
    endtask

    task automatic set_fast(input int n);
        for (int k = 0; k < 4; k++) begin
            b_awd[k] = 0; b_wd[k] = 0; b_bd[k] = 0;
            b_wlast[k] = (k == n-1);
            b_resp[k] = RESP_OKAY;
            b_data[k] = {$urandom, $urandom};
            b_strb[k] = 8'hFF;
            b_addr[k] = 32'(k * 8);
        end
    endtask

    task automatic check_idle_outputs(input bit exp_cmd_ready);
        `CHK("idle_cmd_ready", cmd_ready, exp_cmd_ready);
        `CHK("idle_aw_valid", m_aw_valid, 1'b0);
        `CHK("idle_w_valid", m_w_valid, 1'b0);
        `CHK("idle_s_w_ready", s_w_ready, 1'b0);
        `CHK("idle_b_ready", m_b_ready, 1'b0);
        `CHK("idle_sb_valid", s_b_valid, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, sb_before, n;
        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs(1'b0);
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        check_idle_outputs(1'b1);
        `CHK("rst_sb_id", s_b_id, 0);
        `CHK("rst_sb_resp", s_b_resp, 0);
        `CHK("rst_aw_addr", m_aw_addr, 0);
        @(posedge clk); #1;

        // Single beat with ready slaves: latency 1 to AW/W, 2 to B
        set_fast(1);
        b_addr[0] = 32'h1000; b_data[0] = {32'hAAAAAAAA, 32'hAAAAAAAA};
        run_burst(1, 5'd3, 3'd0, 0);
        c0 = beat_cyc[0];
        `CHK("lat_aw", aw_cyc - c0, 1);
        `CHK("lat_w", w_cyc - c0, 1);
        `CHK("lat_b", mb_cyc - c0, 2);

        // Four-beat burst, one SLVERR beat, back-to-back every 3 cycles
        set_fast(4);
        b_resp[1] = RESP_SLVERR;
        run_burst(4, 5'd9, 3'd2, 0);
        for (int k = 0; k < 3; k++) `CHK("beat_spacing", beat_cyc[k+1] - beat_cyc[k], 3);

        // W before AW: AW ready held off for 5 cycles
        set_fast(1);
        b_addr[0] = 32'h2000; b_awd[0] = 5;
        run_burst(1, 5'd1, 3'd1, 0);
        `CHK("w_first", (w_cyc < aw_cyc), 1'b1);
        `CHK("resp_after_aw", mb_cyc - aw_cyc, 1);

        // s_b backpressure for 4 cycles
        set_fast(2);
        b_resp[0] = RESP_DECERR;
        run_burst(2, 5'd17, 3'd0, 4);

        // Reset during RESP of beat 2 of 4: burst abandoned, no s_b
        set_fast(4);
        sb_before = sb_hs;
        beat(0, 1'b0, 5'd6, 3'd0, 0, 1'b0);
        beat(1, 1'b0, 5'd6, 3'd0, 0, 1'b1);
        @(negedge clk);
        check_idle_outputs(1'b1);
        @(posedge clk); #1;
        set_fast(4);
        run_burst(4, 5'd7, 3'd0, 0);
        `CHK("rst_no_sb", sb_hs, sb_before + 1);

        // Early s_w_last on beat 1 of a 2-beat burst
        set_fast(2);
        b_wlast[0] = 1'b1;
        run_burst(2, 5'd12, 3'd5, 0);

        // Randomized bursts
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) begin
                b_addr[k]  = $urandom & 32'hFFFF_FFF8;
                b_data[k]  = {$urandom, $urandom};
                b_strb[k]  = 8'($urandom);
                b_resp[k]  = 2'($urandom_range(0, 3));
                b_wlast[k] = (k == n-1) ^ ($urandom_range(0, 3) == 0);
                b_awd[k]   = $urandom_range(0, 3);
                b_wd[k]    = $urandom_range(0, 3);
                b_bd[k]    = $urandom_range(0, 2);
            end
            run_burst(n, 5'($urandom), 3'($urandom), $urandom_range(0, 3));
        end

        repeat (4) @(posedge clk);
        @(negedge clk);
        `CHK("left_aw", exp_aw.size(), 0);
        `CHK("left_w", exp_w.size(), 0);
        `CHK("left_b", exp_b.size(), 0);
        `CHK("aw_eq_mb", aw_hs, mb_hs + 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
